// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: hunts for the AA 55 preamble, captures three 12-bit values, pulses pkt_vld/pkt_err.
// Optional TELEM_RX_CHKNIB_EN: abort a packet whose hi byte carries a nonzero upper nibble.
module telemetry_rx #(
  parameter int GAP_CYC = 2500000,
  parameter int GAP_W   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err,
  output logic [7:0]  pkt_cnt
);

  typedef enum logic [2:0] {SYNC1, SYNC2, BV_H, BV_L, CU_H, CU_L, TQ_H, TQ_L} state_t;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       bv_h, cu_h, tq_h;
  logic [7:0]       bv_l, cu_l;
  logic             nib_bad;

  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifdef TELEM_RX_CHKNIB_EN
  assign nib_bad = |rx_data[7:4];
`else
  assign nib_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC1;
      gap_cnt    <= '0;
      bv_h       <= '0;
      cu_h       <= '0;
      tq_h       <= '0;
      bv_l       <= '0;
      cu_l       <= '0;
      batt_v     <= '0;
      avg_curr   <= '0;
      avg_torque <= '0;
      pkt_vld    <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      pkt_vld <= 1'b0;
      pkt_err <= 1'b0;
      if (rx_rdy) begin
        // A byte always takes priority over a gap expiry in the same cycle.
        gap_cnt <= '0;
        case (state)
          SYNC1: if (rx_data == 8'hAA) state <= SYNC2;
          SYNC2: begin
            if (rx_data == 8'h55) begin
              state <= BV_H;
            end else if (rx_data != 8'hAA) begin
              state   <= SYNC1;
              pkt_err <= 1'b1;
            end
          end
          BV_H: begin
            if (nib_bad) begin
              state   <= SYNC1;
              pkt_err <= 1'b1;
            end else begin
              bv_h  <= rx_data[3:0];
              state <= BV_L;
            end
          end
          BV_L: begin
            bv_l  <= rx_data;
            state <= CU_H;
          end
          CU_H: begin
            if (nib_bad) begin
              state   <= SYNC1;
              pkt_err <= 1'b1;
            end else begin
              cu_h  <= rx_data[3:0];
              state <= CU_L;
            end
          end
          CU_L: begin
            cu_l  <= rx_data;
            state <= TQ_H;
          end
          TQ_H: begin
            if (nib_bad) begin
              state   <= SYNC1;
              pkt_err <= 1'b1;
            end else begin
              tq_h  <= rx_data[3:0];
              state <= TQ_L;
            end
          end
          TQ_L: begin
            // Final byte goes straight into the output word so all three values update together.
            batt_v     <= {bv_h, bv_l};
            avg_curr   <= {cu_h, cu_l};
            avg_torque <= {tq_h, rx_data};
            pkt_vld    <= 1'b1;
            pkt_cnt    <= pkt_cnt + 8'd1;
            state      <= SYNC1;
          end
          default: state <= SYNC1;
        endcase
      end else if (state == SYNC1) begin
        gap_cnt <= '0;
      end else if (gap_cnt == GAP_LAST) begin
        state   <= SYNC1;
        pkt_err <= 1'b1;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_sat_inc(gap_cnt);
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Randomized and directed bench for telemetry_rx against a byte-stream reference model.
module tb_telemetry_rx;

  localparam int GAP_CYC = 100;
  localparam int GAP_W   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_rdy = 1'b0;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, pkt_err;
  logic [7:0]  pkt_cnt;

  telemetry_rx #(.GAP_CYC(GAP_CYC), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .pkt_vld(pkt_vld), .pkt_err(pkt_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = hunting, 1 = preamble AA seen, 2 = collecting payload bytes.
  int          m_phase = 0;
  int          m_idle  = 0;
  logic [7:0]  m_pay[$];
  logic [11:0] e_bv = '0, e_cu = '0, e_tq = '0;
  logic [7:0]  e_cnt = '0;
  logic        e_vld = 1'b0, e_err = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic rd, input logic [7:0] d);
    bit nib_chk;
`ifdef TELEM_RX_CHKNIB_EN
    nib_chk = 1'b1;
`else
    nib_chk = 1'b0;
`endif
    e_vld = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_phase = 0; m_idle = 0; m_pay.delete();
      e_bv = '0; e_cu = '0; e_tq = '0; e_cnt = '0;
    end else if (rd) begin
      m_idle = 0;
      if (m_phase == 0) begin
        if (d == 8'hAA) m_phase = 1;
      end else if (m_phase == 1) begin
        if (d == 8'h55) begin
          m_phase = 2;
          m_pay.delete();
        end else if (d != 8'hAA) begin
          m_phase = 0;
          e_err = 1'b1;
        end
      end else begin
        if (nib_chk && (m_pay.size() % 2 == 0) && d[7:4] != 4'h0) begin
          m_phase = 0;
          e_err = 1'b1;
        end else begin
          m_pay.push_back(d);
          if (m_pay.size() == 6) begin
            e_bv  = (12'(m_pay[0]) << 8 | 12'(m_pay[1])) & 12'hFFF;
            e_cu  = (12'(m_pay[2]) << 8 | 12'(m_pay[3])) & 12'hFFF;
            e_tq  = (12'(m_pay[4]) << 8 | 12'(m_pay[5])) & 12'hFFF;
            e_vld = 1'b1;
            e_cnt = e_cnt + 8'd1;
            m_phase = 0;
          end
        end
      end
    end else if (m_phase != 0) begin
      if (m_idle == GAP_CYC - 1) begin
        m_phase = 0;
        m_idle = 0;
        e_err = 1'b1;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [7:0] d);
    rst = r;
    rx_rdy = rd;
    rx_data = d;
    @(posedge clk);
    #1;
    model(r, rd, d);
    chk("pkt_vld", pkt_vld, e_vld);
    chk("pkt_err", pkt_err, e_err);
    chk("batt_v", batt_v, e_bv);
    chk("avg_curr", avg_curr, e_cu);
    chk("avg_torque", avg_torque, e_tq);
    chk("pkt_cnt", pkt_cnt, e_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  // Gap is applied after every byte except the last, so checks can follow the final byte directly.
  task automatic send_seq(input logic [7:0] s[$], input int gap);
    for (int i = 0; i < s.size(); i++) begin
      step(1'b0, 1'b1, s[i]);
      if (i != s.size() - 1) idle(gap);
    end
  endtask

  initial begin
    logic [7:0] q[$];

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    chk("rst_cnt", pkt_cnt, 0);
    chk("rst_bv", batt_v, 0);

    q = '{8'hAA, 8'h55, 8'h0B, 8'h2C, 8'h03, 8'hE8, 8'h07, 8'hFF};
    send_seq(q, 20);
    chk("clean_vld", pkt_vld, 1);
    chk("clean_bv", batt_v, 12'hB2C);
    chk("clean_cu", avg_curr, 12'h3E8);
    chk("clean_tq", avg_torque, 12'h7FF);
    chk("clean_cnt", pkt_cnt, 1);
    idle(1);
    chk("clean_vld_once", pkt_vld, 0);

    q = '{8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h0A, 8'hAA, 8'h05, 8'h55, 8'h00, 8'h01};
    send_seq(q, 3);
    chk("look_bv", batt_v, 12'hAAA);
    chk("look_cu", avg_curr, 12'h555);
    chk("look_tq", avg_torque, 12'h001);
    idle(2);

    q = '{8'hAA, 8'h12};
    send_seq(q, 2);
    chk("badsync_err", pkt_err, 1);
    idle(2);
    q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_seq(q, 1);
    chk("after_bad_bv", batt_v, 12'h102);
    chk("after_bad_cu", avg_curr, 12'h304);
    chk("after_bad_tq", avg_torque, 12'h506);

    q = '{8'hAA, 8'h55, 8'h01, 8'h02};
    send_seq(q, 0);
    idle(99);
    chk("gap_early", pkt_err, 0);
    idle(1);
    chk("gap_err", pkt_err, 1);
    chk("gap_hold_bv", batt_v, 12'h102);
    send_seq(q, 0);
    idle(99);
    q = '{8'h03, 8'h04, 8'h05, 8'h06};
    step(1'b0, 1'b1, q[0]);
    chk("gap_race_err", pkt_err, 0);
    q = '{8'h04, 8'h05, 8'h06};
    send_seq(q, 0);
    chk("gap_race_vld", pkt_vld, 1);

    q = '{8'hAA, 8'h55, 8'h0F, 8'hFF};
    send_seq(q, 0);
    step(1'b1, 1'b0, 8'h00);
    chk("midrst_bv", batt_v, 0);
    chk("midrst_cnt", pkt_cnt, 0);
    q = '{8'hAA, 8'h55, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30};
    send_seq(q, 0);
    chk("midrst_pkt_bv", batt_v, 12'h010);
    chk("midrst_pkt_cu", avg_curr, 12'h020);
    chk("midrst_pkt_tq", avg_torque, 12'h030);
    chk("midrst_pkt_cnt", pkt_cnt, 1);

    step(1'b1, 1'b0, 8'h00);
    for (int p = 0; p < 256; p++) begin
      q = '{8'hAA, 8'h55, 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)};
      send_seq(q, 0);
    end
    chk("wrap_cnt", pkt_cnt, 0);
    q = '{8'hAA, 8'h55, 8'hF1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(q, 0);
`ifdef TELEM_RX_CHKNIB_EN
    chk("nib_vld", pkt_vld, 0);
`else
    chk("nib_vld", pkt_vld, 1);
    chk("nib_bv", batt_v, 12'h100);
`endif
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      b = (sel < 3) ? 8'hAA : (sel < 5) ? 8'h55 : 8'($urandom);
      if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, b);
      if ($urandom_range(0, 29) == 0) idle($urandom_range(95, 105));
      else idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
